// File: rtl/dram_io_burst_pkg.sv
// -----------------------------------------------------------------------------
// dram_io_burst_pkg
// Shared types and constants for the DRAM I/O burst controller:
//   - state_e      : controller FSM states
//   - BL4_CYCLES   : cycles per BL4 burst (DDR, two beats per cycle)
//   - BL8_CYCLES   : cycles per BL8 burst
//   - RD_LAT_W     : width of the read-latency field
//   - last_beat()  : terminal value of the 2-bit beat counter for a burst length
// -----------------------------------------------------------------------------
package dram_io_burst_pkg;

  localparam int BL4_CYCLES = 2;
  localparam int BL8_CYCLES = 4;
  localparam int RD_LAT_W   = 3;

  typedef enum logic [2:0] {
    IDLE,
    WR_PRE,
    WR_BURST,
    WR_POST,
    TURN,
    RD_WAIT,
    RD_BURST
  } state_e;

  // The beat counter counts from 0 up to this value and stops; it never wraps.
  function automatic logic [1:0] last_beat(input logic bl_four);
    return bl_four ? 2'(BL4_CYCLES - 1) : 2'(BL8_CYCLES - 1);
  endfunction

endpackage

// File: rtl/dram_io_rr_arb.sv
// -----------------------------------------------------------------------------
// dram_io_rr_arb
// Two-requester round-robin arbiter (write vs. read) with a last-grant flop.
// When both requests are pending, the type not granted last wins. After reset
// the last grant is taken as read, so the first contest goes to write.
//
// Ports:
//   rclk, arst_l     clock, asynchronous active-low reset
//   wr_req, rd_req   pending requests
//   take             the caller commits the current pick this cycle
//   pick_wr, pick_rd one-hot (or zero) combinational pick
// -----------------------------------------------------------------------------
module dram_io_rr_arb (
  input  logic rclk,
  input  logic arst_l,
  input  logic wr_req,
  input  logic rd_req,
  input  logic take,
  output logic pick_wr,
  output logic pick_rd
);

  logic last_rd;

  always_comb begin
    pick_wr = wr_req & (~rd_req | last_rd);
    pick_rd = rd_req & ~pick_wr;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process ordering in simulation.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      last_rd <= 1'b1;
    end else if (take && (pick_wr || pick_rd)) begin
      last_rd <= pick_rd;
    end
  end

endmodule

// File: rtl/dram_io_burst_ctl.sv
// -----------------------------------------------------------------------------
// dram_io_burst_ctl
// Burst controller for a DDR dq pad slice. Arbitrates write/read burst
// requests, sequences write preamble/burst/postamble/turnaround and read
// latency/capture, and drives the pad-slice controls.
//
// Timing model:
//   - wr_gnt/rd_gnt are registered and pulse in the first cycle of WR_PRE or
//     RD_WAIT.
//   - Write-side pad outputs (drive_enable, drive_data, data_pos/neg) are
//     registered from the current state, so they appear one cycle after the
//     state that produced them; wr_data is consumed in each WR_BURST cycle.
//   - dqs_read (and pad_enable for reads) are registered from the next state,
//     so they line up with the RD_BURST cycles; read data is captured during
//     RD_BURST and presented with rd_vld one cycle later.
//   - Grants are blocked on the first edge after reset release.
//
// Ports:
//   rclk, arst_l                  clock, asynchronous active-low reset
//   wr_req, rd_req / wr_gnt, rd_gnt  request/grant handshake
//   burst_length_four, rd_lat     burst configuration, sampled at grant
//   wr_data                       write beat {neg[3:0], pos[3:0]}
//   data_pos, data_neg            nibbles to the dq pads
//   dram_io_drive_enable, dram_io_drive_data, dram_io_pad_enable, dqs_read
//   io_dram_data_in(_hi)          read nibbles from the pads
//   rd_data, rd_vld               captured read beat {hi, lo}
//   busy                          FSM is not in IDLE
//   wr_burst_cnt, rd_burst_cnt    saturating grant counters, present only when
//                                 DRAM_IO_BURST_CTL_STATS_EN is defined
// -----------------------------------------------------------------------------
module dram_io_burst_ctl
  import dram_io_burst_pkg::*;
#(
  parameter int RD_LAT_MAX = 7
) (
  input  logic                rclk,
  input  logic                arst_l,
  input  logic                wr_req,
  input  logic                rd_req,
  output logic                wr_gnt,
  output logic                rd_gnt,
  input  logic                burst_length_four,
  input  logic [RD_LAT_W-1:0] rd_lat,
  input  logic [7:0]          wr_data,
  output logic [3:0]          data_pos,
  output logic [3:0]          data_neg,
  output logic                dram_io_drive_enable,
  output logic                dram_io_drive_data,
  output logic                dram_io_pad_enable,
  output logic                dqs_read,
  input  logic [3:0]          io_dram_data_in,
  input  logic [3:0]          io_dram_data_in_hi,
  output logic [7:0]          rd_data,
  output logic                rd_vld,
  output logic                busy
`ifdef DRAM_IO_BURST_CTL_STATS_EN
  ,
  output logic [15:0]         wr_burst_cnt,
  output logic [15:0]         rd_burst_cnt
`endif
);

  state_e              state, next_state;
  logic                rst_done;
  logic [1:0]          beat, beat_d;
  logic [RD_LAT_W-1:0] lat_cnt, lat_cnt_d;
  logic                bl_four, bl_four_d;
  logic                pick_wr, pick_rd, fire, beat_end;
  logic [RD_LAT_W-1:0] rd_lat_clamped;

  logic       wr_gnt_d, rd_gnt_d;
  logic       drive_enable_d, drive_data_d, pad_enable_d, dqs_read_d;
  logic [3:0] data_pos_d, data_neg_d;
  logic [7:0] rd_data_d;
  logic       rd_vld_d;

  assign fire     = (state == IDLE) && rst_done && (wr_req || rd_req);
  assign beat_end = (beat == last_beat(bl_four));
  assign busy     = (state != IDLE);

  assign rd_lat_clamped = (int'(rd_lat) > RD_LAT_MAX) ? RD_LAT_W'(RD_LAT_MAX) : rd_lat;

  dram_io_rr_arb u_arb (
    .rclk    (rclk),
    .arst_l  (arst_l),
    .wr_req  (wr_req),
    .rd_req  (rd_req),
    .take    (fire),
    .pick_wr (pick_wr),
    .pick_rd (pick_rd)
  );

  // State register and burst bookkeeping. rst_done holds off grants on the
  // first edge after reset release.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state    <= IDLE;
      rst_done <= 1'b0;
      beat     <= '0;
      lat_cnt  <= '0;
      bl_four  <= 1'b0;
    end else begin
      state    <= next_state;
      rst_done <= 1'b1;
      beat     <= beat_d;
      lat_cnt  <= lat_cnt_d;
      bl_four  <= bl_four_d;
    end
  end

  // Next-state logic. Burst length and read latency are latched at grant so
  // changes on the inputs mid-burst do not disturb the burst in progress.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    beat_d     = beat;
    lat_cnt_d  = lat_cnt;
    bl_four_d  = bl_four;
    case (state)
      IDLE: begin
        if (fire) begin
          bl_four_d  = burst_length_four;
          lat_cnt_d  = rd_lat_clamped;
          beat_d     = '0;
          next_state = pick_wr ? WR_PRE : RD_WAIT;
        end
      end
      WR_PRE:   next_state = WR_BURST;
      WR_BURST: begin
        if (beat_end) begin
          beat_d     = '0;
          next_state = WR_POST;
        end else begin
          beat_d = beat + 2'd1;
        end
      end
      WR_POST:  next_state = TURN;
      TURN:     next_state = IDLE;
      RD_WAIT: begin
        if (lat_cnt == '0) begin
          next_state = RD_BURST;
        end else begin
          lat_cnt_d = lat_cnt - RD_LAT_W'(1);
        end
      end
      RD_BURST: begin
        if (beat_end) begin
          beat_d     = '0;
          next_state = IDLE;
        end else begin
          beat_d = beat + 2'd1;
        end
      end
      default:  next_state = IDLE;
    endcase
  end

  // Output decode: values loaded into the output registers at the next edge.
  always_comb begin
    wr_gnt_d       = fire && pick_wr;
    rd_gnt_d       = fire && pick_rd;
    drive_enable_d = (state == WR_PRE) || (state == WR_BURST) || (state == WR_POST);
    drive_data_d   = (state == WR_BURST);
    dqs_read_d     = (next_state == RD_BURST);
    pad_enable_d   = drive_enable_d || dqs_read_d;
    data_pos_d     = drive_data_d ? wr_data[3:0] : 4'h0;
    data_neg_d     = drive_data_d ? wr_data[7:4] : 4'h0;
    rd_vld_d       = (state == RD_BURST);
    rd_data_d      = rd_vld_d ? {io_dram_data_in_hi, io_dram_data_in} : rd_data;
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      wr_gnt               <= 1'b0;
      rd_gnt               <= 1'b0;
      dram_io_drive_enable <= 1'b0;
      dram_io_drive_data   <= 1'b0;
      dram_io_pad_enable   <= 1'b0;
      dqs_read             <= 1'b0;
      data_pos             <= 4'h0;
      data_neg             <= 4'h0;
      rd_vld               <= 1'b0;
      rd_data              <= 8'h00;
    end else begin
      wr_gnt               <= wr_gnt_d;
      rd_gnt               <= rd_gnt_d;
      dram_io_drive_enable <= drive_enable_d;
      dram_io_drive_data   <= drive_data_d;
      dram_io_pad_enable   <= pad_enable_d;
      dqs_read             <= dqs_read_d;
      data_pos             <= data_pos_d;
      data_neg             <= data_neg_d;
      rd_vld               <= rd_vld_d;
      rd_data              <= rd_data_d;
    end
  end

`ifdef DRAM_IO_BURST_CTL_STATS_EN
  // Grant counters, saturating so a long run never wraps back to small values.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      wr_burst_cnt <= 16'h0000;
      rd_burst_cnt <= 16'h0000;
    end else begin
      if (fire && pick_wr && (wr_burst_cnt != 16'hFFFF)) begin
        wr_burst_cnt <= wr_burst_cnt + 16'd1;
      end
      if (fire && pick_rd && (rd_burst_cnt != 16'hFFFF)) begin
        rd_burst_cnt <= rd_burst_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dram_io_burst_ctl.sv
// -----------------------------------------------------------------------------
// tb_dram_io_burst_ctl
// Directed self-checking bench for dram_io_burst_ctl. Cycle numbers in tags
// count from the grant cycle (or from reset release where noted). Outputs are
// sampled 1 ns after the rising edge; inputs are driven at the same point.
// Define DRAM_IO_BURST_CTL_STATS_EN to also check the burst counters.
// -----------------------------------------------------------------------------
module tb_dram_io_burst_ctl;

  logic       rclk = 1'b0;
  logic       arst_l = 1'b0;
  logic       wr_req = 1'b0, rd_req = 1'b0;
  logic       wr_gnt, rd_gnt;
  logic       burst_length_four = 1'b0;
  logic [2:0] rd_lat = 3'd0;
  logic [7:0] wr_data = 8'h00;
  logic [3:0] data_pos, data_neg;
  logic       dram_io_drive_enable, dram_io_drive_data, dram_io_pad_enable, dqs_read;
  logic [3:0] io_dram_data_in = 4'h0, io_dram_data_in_hi = 4'h0;
  logic [7:0] rd_data;
  logic       rd_vld, busy;
`ifdef DRAM_IO_BURST_CTL_STATS_EN
  logic [15:0] wr_burst_cnt, rd_burst_cnt;
`endif

  int num_checks = 0;
  int num_errors = 0;

  always #5 rclk = ~rclk;

  dram_io_burst_ctl dut (
    .rclk                 (rclk),
    .arst_l               (arst_l),
    .wr_req               (wr_req),
    .rd_req               (rd_req),
    .wr_gnt               (wr_gnt),
    .rd_gnt               (rd_gnt),
    .burst_length_four    (burst_length_four),
    .rd_lat               (rd_lat),
    .wr_data              (wr_data),
    .data_pos             (data_pos),
    .data_neg             (data_neg),
    .dram_io_drive_enable (dram_io_drive_enable),
    .dram_io_drive_data   (dram_io_drive_data),
    .dram_io_pad_enable   (dram_io_pad_enable),
    .dqs_read             (dqs_read),
    .io_dram_data_in      (io_dram_data_in),
    .io_dram_data_in_hi   (io_dram_data_in_hi),
    .rd_data              (rd_data),
    .rd_vld               (rd_vld),
    .busy                 (busy)
`ifdef DRAM_IO_BURST_CTL_STATS_EN
    ,
    .wr_burst_cnt         (wr_burst_cnt),
    .rd_burst_cnt         (rd_burst_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  // All outputs packed into one word so "everything is zero" is one compare.
  function automatic logic [31:0] all_outs();
    return {4'h0, wr_gnt, rd_gnt, dram_io_drive_enable, dram_io_drive_data,
            dram_io_pad_enable, dqs_read, rd_vld, busy, data_pos, data_neg, rd_data, 4'h0};
  endfunction

  // Hold reset for two edges, check the reset state, release between edges.
  task automatic do_reset(input string tag);
    arst_l = 1'b0;
    step();
    step();
    check({tag, "_rst_outs"}, all_outs(), 32'h0);
    arst_l = 1'b1;
  endtask

  logic [7:0] rd_beats [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  int         exp_gnt_cyc [5] = '{2, 8, 12, 18, 22};
  logic       exp_gnt_wr  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int   n_gnt;
    int   gnt_cyc [5];
    logic gnt_wr  [5];
    int   rd_gnt_cyc [2];
    logic [3:0] dqs_seen;

    // ---------------- Write BL4, A5 then 3C ----------------
    do_reset("t1");
    step();
    step();
    burst_length_four = 1'b1;
    wr_req = 1'b1;
    step();                                   // cycle 0
    check("t1_wr_gnt_c0", wr_gnt, 1'b1);
    check("t1_busy_c0", busy, 1'b1);
    wr_req = 1'b0;
    step();                                   // cycle 1: preamble on pins
    check("t1_de_c1", dram_io_drive_enable, 1'b1);
    check("t1_dd_c1", dram_io_drive_data, 1'b0);
    check("t1_pe_c1", dram_io_pad_enable, 1'b1);
    check("t1_gnt_c1", wr_gnt, 1'b0);
    wr_data = 8'hA5;
    step();                                   // cycle 2
    check("t1_de_c2", dram_io_drive_enable, 1'b1);
    check("t1_dd_c2", dram_io_drive_data, 1'b1);
    check("t1_data_c2", {data_pos, data_neg}, 8'h5A);
    wr_data = 8'h3C;
    step();                                   // cycle 3
    check("t1_de_c3", dram_io_drive_enable, 1'b1);
    check("t1_data_c3", {data_pos, data_neg}, 8'hC3);
    wr_data = 8'h00;
    step();                                   // cycle 4: postamble
    check("t1_de_c4", dram_io_drive_enable, 1'b1);
    check("t1_dd_c4", dram_io_drive_data, 1'b0);
    check("t1_busy_c4", busy, 1'b1);
    step();                                   // cycle 5
    check("t1_busy_c5", busy, 1'b0);
    check("t1_de_c5", dram_io_drive_enable, 1'b0);

    // ---------------- Read BL8, rd_lat=2 ----------------
    rd_req = 1'b1;
    burst_length_four = 1'b0;
    rd_lat = 3'd2;
    step();                                   // cycle 0
    check("t2_rd_gnt_c0", rd_gnt, 1'b1);
    rd_req = 1'b0;
    burst_length_four = 1'b1;                 // must not shorten this burst
    rd_lat = 3'd0;
    for (int c = 1; c <= 8; c++) begin
      step();
      {io_dram_data_in_hi, io_dram_data_in} = (c >= 3 && c <= 6) ? rd_beats[c-3] : 8'hFF;
      check($sformatf("t2_dqs_c%0d", c), dqs_read, (c >= 3 && c <= 6));
      check($sformatf("t2_vld_c%0d", c), rd_vld, (c >= 4 && c <= 7));
      if (c >= 4 && c <= 7) check($sformatf("t2_data_c%0d", c), rd_data, rd_beats[c-4]);
      if (c == 3) check("t2_pe_c3", dram_io_pad_enable, 1'b1);
    end

    // ---------------- Both requests held from reset ----------------
    wr_req = 1'b1;
    rd_req = 1'b1;
    burst_length_four = 1'b1;
    rd_lat = 3'd0;
    do_reset("t3");
    n_gnt = 0;
    for (int c = 1; c <= 30; c++) begin     // cycles counted from reset release
      step();
      if (wr_gnt || rd_gnt) begin
        if (n_gnt < 5) begin
          gnt_cyc[n_gnt] = c;
          gnt_wr[n_gnt]  = wr_gnt;
        end
        n_gnt++;
        if (n_gnt == 5) begin
          wr_req = 1'b0;
          rd_req = 1'b0;
        end
      end
    end
    check("t3_num_gnt", n_gnt, 5);
    for (int i = 0; i < 5 && i < n_gnt; i++) begin
      check($sformatf("t3_gnt%0d_cyc", i), gnt_cyc[i], exp_gnt_cyc[i]);
      check($sformatf("t3_gnt%0d_is_wr", i), gnt_wr[i], exp_gnt_wr[i]);
    end
`ifdef DRAM_IO_BURST_CTL_STATS_EN
    check("t3_wr_burst_cnt", wr_burst_cnt, 16'd3);
    check("t3_rd_burst_cnt", rd_burst_cnt, 16'd2);
`endif

    // ---------------- Back-to-back BL4 reads, rd_lat=0 ----------------
    rd_req = 1'b1;
    do_reset("t4");
    n_gnt = 0;
    dqs_seen = '0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c >= 3 && c <= 6) dqs_seen[c-3] = dqs_read;
      if (rd_gnt && n_gnt < 2) begin
        rd_gnt_cyc[n_gnt] = c;
        n_gnt++;
      end
    end
    rd_req = 1'b0;
    check("t4_num_gnt", n_gnt, 2);
    if (n_gnt == 2) begin
      check("t4_gnt0_cyc", rd_gnt_cyc[0], 2);
      check("t4_gnt1_cyc", rd_gnt_cyc[1], 6);
    end
    check("t4_dqs_c3_6", dqs_seen, 4'b0011);

    // ---------------- Reset pulsed during WR_BURST ----------------
    wr_req = 1'b1;
    burst_length_four = 1'b0;
    do_reset("t5");
    step();                                   // cycle 1 after release
    step();                                   // cycle 2: grant
    check("t5_wr_gnt", wr_gnt, 1'b1);
    wr_req = 1'b0;
    wr_data = 8'h96;
    step();                                   // WR_PRE
    step();                                   // WR_BURST
    step();                                   // WR_BURST, data on pins
    check("t5_dd_before", dram_io_drive_data, 1'b1);
    arst_l = 1'b0;
    #1;
    check("t5_outs_zero", all_outs(), 32'h0);
    check("t5_idle", busy, 1'b0);
    wr_req = 1'b1;
    step();
    arst_l = 1'b1;
    step();                                   // first edge after release
    check("t5_no_gnt_edge1", wr_gnt, 1'b0);
    check("t5_no_post_edge1", dram_io_drive_enable, 1'b0);
    step();                                   // second edge
    check("t5_gnt_edge2", wr_gnt, 1'b1);
    wr_req = 1'b0;
    repeat (8) step();
    check("t5_idle_end", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/dram_io_burst_ctl.md
DRAM_IO_BURST_CTL -- requirements
Module: dram_io_burst_ctl

Interface
REQ-001 Parameter: RD_LAT_MAX, default 7, meaning the largest legal rd_lat value; rd_lat width is 3 bits.
REQ-002 rclk  input  1  clock; all state changes on the rising edge.
REQ-003 arst_l  input  1  asynchronous active-low reset.
REQ-004 wr_req, rd_req  input  1 each  burst requests; each is held until granted.
REQ-005 wr_gnt, rd_gnt  output  1 each  one-cycle grant pulses; the request is consumed on the pulse.
REQ-006 burst_length_four  input  1  1 selects BL4 (2 cycles), 0 selects BL8 (4 cycles); sampled at grant.
REQ-007 rd_lat  input  3  idle cycles from grant to the first read-capture cycle; sampled at grant.
REQ-008 wr_data  input  8  write beat: [3:0] is the positive edge, [7:4] is the negative edge; consumed in every WR_BURST cycle.
REQ-009 data_pos, data_neg  output  4 each  nibbles driven to the dq pad slice.
REQ-010 dram_io_drive_enable, dram_io_drive_data, dram_io_pad_enable, dqs_read  output  1 each  pad-slice controls.
REQ-011 io_dram_data_in, io_dram_data_in_hi  input  4 each  captured read nibbles.
REQ-012 rd_data  output  8  captured read beat, {hi, lo}.
REQ-013 rd_vld  output  1  rd_data is valid this cycle.
REQ-014 busy  output  1  FSM is not in IDLE.

Function
REQ-015 FSM states are IDLE, WR_PRE, WR_BURST, WR_POST, TURN, RD_WAIT, RD_BURST.
REQ-016 IDLE: on any pending request, assert the arbiter-selected grant and move to WR_PRE or RD_WAIT in the same cycle.
REQ-017 Arbitration is round-robin: when both requests are pending, the type not granted last wins; after reset the last grant is taken as read, so the first contest goes to write.
REQ-018 WR_PRE lasts 1 cycle with drive_enable=1, pad_enable=1, drive_data=0 (preamble).
REQ-019 WR_BURST lasts 2 cycles (BL4) or 4 cycles (BL8) with drive_enable=1, drive_data=1, data_pos=wr_data[3:0], data_neg=wr_data[7:4], all registered one cycle after the FSM enters or stays in WR_BURST.
REQ-020 WR_POST lasts 1 cycle with drive_enable=1, drive_data=0, and then moves to TURN.
REQ-021 TURN is 1 cycle with all drives 0 and then returns to IDLE; a read may be granted no earlier than the cycle after TURN.
REQ-022 RD_WAIT counts rd_lat cycles; rd_lat=0 enters RD_BURST in the next cycle.
REQ-023 RD_BURST lasts 2 or 4 cycles with dqs_read=1 and pad_enable=1.
REQ-024 In RD_BURST, rd_data is registered from the inputs and rd_vld is asserted exactly one cycle after each RD_BURST cycle.
REQ-025 After RD_BURST, return to IDLE; back-to-back reads need no TURN cycle.
REQ-026 The beat counter is 2 bits and terminates at 1 (BL4) or 3 (BL8); it never wraps within a burst.
REQ-027 Requests that arrive while busy are held by the requester and are not granted until IDLE.
REQ-028 burst_length_four and rd_lat changes mid-burst have no effect on the burst in progress.

Reset
REQ-029 arst_l low forces, asynchronously: FSM to IDLE, all outputs to 0, counters to 0, last-grant to read.
REQ-030 Reset mid-burst aborts the burst with no post-amble; after deassertion, the first grant occurs no earlier than the second rising edge.

Configuration
REQ-031 Macro DRAM_IO_BURST_CTL_STATS_EN:
- Defined: add outputs wr_burst_cnt[15:0] and rd_burst_cnt[15:0], each incremented on its grant, saturating at 16'hFFFF, and cleared by reset.
- Undefined: these ports and the associated logic are absent, and behaviour is otherwise identical.

Structure
REQ-032 Package dram_io_burst_pkg holds the state enum, BL4_CYCLES=2, BL8_CYCLES=4, and RD_LAT_W=3.
REQ-033 Sub-module dram_io_rr_arb is a 2-requester round-robin arbiter with a last-grant flop.

Verification
REQ-034 wr_req with BL4 and wr_data 8'hA5 then 8'h3C:
- wr_gnt is asserted at cycle 0.
- drive_enable is high for cycles 1-4.
- data_pos/data_neg are 5/A at cycle 2 and C/3 at cycle 3.
- busy drops at cycle 5.
REQ-035 rd_req with BL8, rd_lat=2, and inputs {hi,lo}=8'h11,22,33,44:
- dqs_read is high for 4 cycles beginning at cycle 3.
- rd_vld returns 11,22,33,44 on cycles 4-7.
REQ-036 wr_req and rd_req both held from reset:
- Grants are write, then read, then write.
- The read grant comes 1 cycle after TURN.
REQ-037 Two back-to-back BL4 reads with rd_lat=0: the second rd_gnt is asserted 1 cycle after the first RD_BURST ends.
REQ-038 arst_l pulsed low during WR_BURST: all outputs read 0 immediately, and the FSM is in IDLE.
REQ-039 With DRAM_IO_BURST_CTL_STATS_EN, after 3 writes and 2 reads: wr_burst_cnt=3 and rd_burst_cnt=2.
